// File: rtl/divider.sv
// divider: iterative restoring divider; define DIVIDER_SIGNED_EN to add signed_op (two's-complement divide).
// Latency: valid pulses WIDTH+1 cycles after the start edge; divide-by-zero and signed MIN/-1 take a 1-cycle fast path.
// Backpressure: ready=0 while busy (CALC, DONE); start is ignored unless ready=1 and operands are sampled only on acceptance.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             zero_flag,
  output logic             exception_flag,
  output logic             overflow_flag
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] dvs_r;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             div_zero;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             ovf;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign accept   = start && (state == IDLE);
  assign div_zero = (divisor == '0);

`ifdef DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign ovf     = signed_op && (dividend == MIN_VAL) && (divisor == '1);
`else
  assign dvd_neg = 1'b0;
  assign dvs_neg = 1'b0;
  assign ovf     = 1'b0;
`endif

  // The core always divides magnitudes; MIN negates to itself, which is the correct unsigned magnitude.
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  // One restoring step: the shifted partial remainder is WIDTH+1 bits, the trial MSB is its sign.
  always_comb begin
    r_sh  = {rem_r, q_r[WIDTH-1]};
    trial = r_sh - {1'b0, dvs_r};
    if (!trial[WIDTH]) begin
      r_nxt = trial[WIDTH-1:0];
      q_nxt = {q_r[WIDTH-2:0], 1'b1};
    end else begin
      r_nxt = r_sh[WIDTH-1:0];
      q_nxt = {q_r[WIDTH-2:0], 1'b0};
    end
    q_fin = neg_q ? -q_nxt : q_nxt;
    r_fin = neg_r ? -r_nxt : r_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (div_zero || ovf) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      rem_r          <= '0;
      q_r            <= '0;
      dvs_r          <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      quotient       <= '0;
      remainder      <= '0;
      zero_flag      <= 1'b0;
      exception_flag <= 1'b0;
      overflow_flag  <= 1'b0;
    end else if (accept) begin
      cnt            <= '0;
      rem_r          <= '0;
      q_r            <= dvd_mag;
      dvs_r          <= dvs_mag;
      neg_q          <= dvd_neg ^ dvs_neg;
      neg_r          <= dvd_neg;
      quotient       <= '0;
      remainder      <= '0;
      zero_flag      <= 1'b0;
      exception_flag <= 1'b0;
      overflow_flag  <= 1'b0;
      // Fast-path results are written here so they are ready on entry to DONE.
      if (div_zero) begin
        quotient       <= '1;
        remainder      <= dividend;
        exception_flag <= 1'b1;
      end else if (ovf) begin
        quotient      <= dividend;
        overflow_flag <= 1'b1;
      end
    end else if (state == CALC) begin
      rem_r <= r_nxt;
      q_r   <= q_nxt;
      cnt   <= cnt + CW'(1);
      if (cnt == LAST) begin
        quotient  <= q_fin;
        remainder <= r_fin;
        zero_flag <= (q_fin == '0);
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a negedge monitor pops and compares on valid.
module tb_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        signed_op;
  logic        ready;
  logic        valid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        zero_flag;
  logic        exception_flag;
  logic        overflow_flag;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    logic        e;
    logic        o;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  divider #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .dividend       (dividend),
    .divisor        (divisor),
`ifdef DIVIDER_SIGNED_EN
    .signed_op      (signed_op),
`endif
    .ready          (ready),
    .valid          (valid),
    .quotient       (quotient),
    .remainder      (remainder),
    .zero_flag      (zero_flag),
    .exception_flag (exception_flag),
    .overflow_flag  (overflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives a request and waits (bounded) for acceptance; called at a negedge, returns at a negedge.
  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic push,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic ez, input logic ee, input logic eo,
                       input int elat, output int acc);
    exp_t e;
    logic rd;
    bit   got;
    got = 0;
    acc = -1;
    dividend  = a;
    divisor   = b;
    signed_op = sgn;
    start     = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      rd = ready;
      @(posedge clk);
      #1;
      if (rd) begin
        got = 1;
        acc = cyc;
      end
    end
    if (!got) begin
      chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    end else begin
      n_vec++;
      if (push) begin
        e.name = name; e.q = eq; e.r = er; e.z = ez; e.e = ee; e.o = eo;
        e.lat = elat; e.acc = acc;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: every valid must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_q"},   quotient,       e.q);
          chk({e.name, "_r"},   remainder,      e.r);
          chk({e.name, "_zf"},  32'(zero_flag),      32'(e.z));
          chk({e.name, "_ef"},  32'(exception_flag), 32'(e.e));
          chk({e.name, "_of"},  32'(overflow_flag),  32'(e.o));
          chk({e.name, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required < 500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; signed_op = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_q",     quotient,   32'd0);
    chk("rst_r",     remainder,  32'd0);
    chk("rst_flags", {29'd0, zero_flag, exception_flag, overflow_flag}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal divide, full-length latency
    issue("div100_7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 33, a0);
    drain("div100_7");
    repeat (3) @(negedge clk);
    chk("hold_q", quotient, 32'd14);
    chk("hold_r", remainder, 32'd2);

    // Divide by zero fast path
    issue("div5_0", 32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, 1'b0, 1, a0);
    drain("div5_0");

    // Zero quotient, then back-to-back with start held through CALC and DONE
    issue("div3_10", 32'd3, 32'd10, 1'b0, 1'b1, 32'd0, 32'd3, 1'b1, 1'b0, 1'b0, 33, a0);
    issue("divmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0, 33, a1);
    chk("b2b_spacing", 32'(a1 - a0), 32'd34);
    drain("divmax_1");

    issue("div0_5", 32'd0, 32'd5, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 33, a0);
    issue("divmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 33, a0);
    issue("div0_0", 32'd0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1, a0);
    drain("div0_0");

    // Start pulsed mid-calculation with different operands must be ignored
    issue("div1000_3", 32'd1000, 32'd3, 1'b0, 1'b1, 32'd333, 32'd1, 1'b0, 1'b0, 1'b0, 33, a0);
    repeat (9) @(negedge clk);
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    chk("busy_ready", 32'(ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    drain("div1000_3");

    // Reset mid-calculation aborts without a valid pulse
    issue("div50_5_abort", 32'd50, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 0, a0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    repeat (40) @(negedge clk);
    issue("div8_2", 32'd8, 32'd2, 1'b0, 1'b1, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 33, a0);
    drain("div8_2");

`ifdef DIVIDER_SIGNED_EN
    issue("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33, a0);
    issue("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b1, 1, a0);
    drain("sdiv_min_m1");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
